// File: rtl/lmem_pkg.sv
// Shared defaults and types for the layer-memory arbiter.
package lmem_pkg;

    localparam int unsigned LMEM_AW       = 12;
    localparam int unsigned LMEM_DW       = 13;
    localparam int unsigned LMEM_MAX_HOLD = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/lmem_rd_tag_pipe.sv
// Two-stage {valid, requester-id} pipe; its output stage lines up with the
// cycle in which the memory presents read data.
module lmem_rd_tag_pipe
    import lmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push_valid,
    input  logic push_id,
    output logic rvalid0,
    output logic rvalid1
);

    rd_tag_t s1_q, s1_d;
    rd_tag_t s2_q, s2_d;

    always_comb begin
        s1_d.valid = push_valid;
        s1_d.id    = push_id;
        s2_d       = s1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign rvalid0 = s2_q.valid && !s2_q.id;
    assign rvalid1 = s2_q.valid &&  s2_q.id;

endmodule

// File: rtl/lmem_arbiter.sv
// Two-requester layer-memory arbiter with lock/hold limit and registered
// memory strobes; read data returns two cycles after accept, in order.
//   state     | meaning
//   ST_IDLE   | no owner; lone valid wins, tie goes to the requester != last_grant
//   ST_GRANT0 | requester 0 owns the port; a cycle with no ready is the turnaround
//   ST_GRANT1 | requester 1 owns the port; a cycle with no ready is the turnaround
module lmem_arbiter
    import lmem_pkg::*;
#(
    parameter int unsigned AW       = LMEM_AW,
    parameter int unsigned DW       = LMEM_DW,
    parameter int unsigned MAX_HOLD = LMEM_MAX_HOLD
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req1_valid,
    input  logic          req0_we,
    input  logic          req1_we,
    input  logic          req0_sel,
    input  logic          req1_sel,
    input  logic [AW-1:0] req0_addr,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic [DW-1:0] req1_wdata,
    input  logic          req0_lock,
    input  logic          req1_lock,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          req0_rvalid,
    output logic          req1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          cwr,
    output logic          crd,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    output logic          csel,
    input  logic [DW-1:0] cdata_rd
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_inc;
    logic          stay0, stay1;
    logic          rdy0, rdy1;

    logic          cwr_q, cwr_d;
    logic          crd_q, crd_d;
    logic [AW-1:0] caddr_wr_q, caddr_wr_d;
    logic [AW-1:0] caddr_rd_q, caddr_rd_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic          csel_q, csel_d;

    logic          acc0, acc1, acc;
    logic          m_we, m_sel;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    assign hold_inc = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + HW'(1);

    assign stay0 = req0_valid &&
                   (hold_q == '0 || !req1_valid || (req0_lock && hold_q < HW'(MAX_HOLD)));
    assign stay1 = req1_valid &&
                   (hold_q == '0 || !req0_valid || (req1_lock && hold_q < HW'(MAX_HOLD)));

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid && (!req1_valid || last_q)) begin
                    rdy0    = 1'b1;
                    state_d = ST_GRANT0;
                    hold_d  = HW'(1);
                    last_d  = 1'b0;
                end else if (req1_valid) begin
                    rdy1    = 1'b1;
                    state_d = ST_GRANT1;
                    hold_d  = HW'(1);
                    last_d  = 1'b1;
                end
            end
            ST_GRANT0: begin
                if (stay0) begin
                    rdy0   = 1'b1;
                    hold_d = hold_inc;
                    last_d = 1'b0;
                end else begin
                    hold_d  = '0;
                    state_d = req1_valid ? ST_GRANT1 : ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (stay1) begin
                    rdy1   = 1'b1;
                    hold_d = hold_inc;
                    last_d = 1'b1;
                end else begin
                    hold_d  = '0;
                    state_d = req0_valid ? ST_GRANT0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Ready is forced low while reset is held, even though IDLE would grant.
    assign req0_ready = rdy0 && reset;
    assign req1_ready = rdy1 && reset;

    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;
    assign acc  = acc0 || acc1;

    always_comb begin
        m_we    = req0_we;
        m_sel   = req0_sel;
        m_addr  = req0_addr;
        m_wdata = req0_wdata;
        if (acc1) begin
            m_we    = req1_we;
            m_sel   = req1_sel;
            m_addr  = req1_addr;
            m_wdata = req1_wdata;
        end
    end

    always_comb begin
        cwr_d      = acc && m_we;
        crd_d      = acc && !m_we;
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = csel_q;
        if (acc) begin
            csel_d = m_sel;
            if (m_we) begin
                caddr_wr_d = m_addr;
                cdata_wr_d = m_wdata;
            end else begin
                caddr_rd_d = m_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            last_q     <= 1'b1;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;
    assign rdata    = cdata_rd;

    lmem_rd_tag_pipe u_rd_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .push_valid(acc && !m_we),
        .push_id   (acc1),
        .rvalid0   (req0_rvalid),
        .rvalid1   (req1_rvalid)
    );

endmodule

// File: tb/tb_lmem_arbiter.sv
// Bench for lmem_arbiter: directed scenarios plus random two-requester
// traffic against a memory model and an in-order read scoreboard.
module tb_lmem_arbiter;
    import lmem_pkg::*;

    localparam int AW = LMEM_AW;
    localparam int DW = LMEM_DW;
    localparam int MH = LMEM_MAX_HOLD;

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    v     = '0;
    logic [1:0]    we    = '0;
    logic [1:0]    sel   = '0;
    logic [1:0]    lock  = '0;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    rdy, rv;
    logic [DW-1:0] rdata, cdata_wr;
    logic [DW-1:0] cdata_rd;
    logic          cwr, crd, csel;
    logic [AW-1:0] caddr_wr, caddr_rd;

    logic          mem_clear = 1'b0;
    logic          mem_poke  = 1'b0;
    logic          poke_sel  = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;
    logic [DW-1:0] mem     [2][4096];
    logic [DW-1:0] ref_mem [2][4096];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (v[0]),
        .req1_valid (v[1]),
        .req0_we    (we[0]),
        .req1_we    (we[1]),
        .req0_sel   (sel[0]),
        .req1_sel   (sel[1]),
        .req0_addr  (addr[0]),
        .req1_addr  (addr[1]),
        .req0_wdata (wdata[0]),
        .req1_wdata (wdata[1]),
        .req0_lock  (lock[0]),
        .req1_lock  (lock[1]),
        .req0_ready (rdy[0]),
        .req1_ready (rdy[1]),
        .req0_rvalid(rv[0]),
        .req1_rvalid(rv[1]),
        .rdata      (rdata),
        .cwr        (cwr),
        .crd        (crd),
        .caddr_wr   (caddr_wr),
        .caddr_rd   (caddr_rd),
        .cdata_wr   (cdata_wr),
        .csel       (csel),
        .cdata_rd   (cdata_rd)
    );

    function automatic logic [DW-1:0] init_pat(input int s, input int a);
        return DW'(a * 37 + s * 1001 + 5);
    endfunction

    // Layer memory: one-cycle read latency after crd.
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) begin
                mem[0][i] <= init_pat(0, i);
                mem[1][i] <= init_pat(1, i);
            end
        end else if (mem_poke) begin
            mem[poke_sel][poke_addr] <= poke_data;
        end else if (cwr) begin
            mem[csel][caddr_wr] <= cdata_wr;
        end
        if (crd) cdata_rd <= mem[csel][caddr_rd];
    end

    task automatic idle_inputs();
        v = '0; we = '0; sel = '0; lock = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        v = 2'b11;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_checks++; if (rdy !== 2'b00) $display("FAIL reset_ready: got %b want 00", rdy); else n_pass++;
        n_checks++; if (rv !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", rv); else n_pass++;
        n_checks++; if ({cwr, crd} !== 2'b00) $display("FAIL reset_strobes: got %b want 00", {cwr, crd}); else n_pass++;
        n_checks++;
        if ({caddr_wr, caddr_rd, cdata_wr, csel} !== '0)
            $display("FAIL reset_bus: got %h %h %h %b want zeros", caddr_wr, caddr_rd, cdata_wr, csel);
        else n_pass++;
        v = '0;
    endtask

    task automatic test_write();
        apply_reset();
        v[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h005; wdata[0] = 13'h0123; sel[0] = 1'b0;
        #2;
        n_checks++; if (rdy !== 2'b01) $display("FAIL write_ready: got %b want 01", rdy); else n_pass++;
        @(negedge clk); v = '0; #2;
        n_checks++; if ({cwr, crd} !== 2'b10) $display("FAIL write_strobes: got %b want 10", {cwr, crd}); else n_pass++;
        n_checks++; if (caddr_wr !== 12'h005) $display("FAIL write_addr: got %h want 005", caddr_wr); else n_pass++;
        n_checks++; if (cdata_wr !== 13'h0123) $display("FAIL write_data: got %h want 0123", cdata_wr); else n_pass++;
        n_checks++; if (csel !== 1'b0) $display("FAIL write_sel: got %b want 0", csel); else n_pass++;
        @(negedge clk); #2;
        n_checks++;
        if (cwr !== 1'b0 || caddr_wr !== 12'h005)
            $display("FAIL write_hold: got cwr=%b addr=%h want 0 005", cwr, caddr_wr);
        else n_pass++;
    endtask

    task automatic test_read();
        @(negedge clk);
        poke_sel = 1'b1; poke_addr = 12'h3FF; poke_data = 13'h0AAA; mem_poke = 1'b1;
        @(negedge clk);
        mem_poke = 1'b0;
        apply_reset();
        v[1] = 1'b1; we[1] = 1'b0; addr[1] = 12'h3FF; sel[1] = 1'b1;
        #2;
        n_checks++; if (rdy !== 2'b10) $display("FAIL read_ready: got %b want 10", rdy); else n_pass++;
        @(negedge clk); v = '0; #2;
        n_checks++; if ({cwr, crd} !== 2'b01) $display("FAIL read_strobes: got %b want 01", {cwr, crd}); else n_pass++;
        n_checks++;
        if (caddr_rd !== 12'h3FF || csel !== 1'b1)
            $display("FAIL read_addr: got %h sel %b want 3ff 1", caddr_rd, csel);
        else n_pass++;
        n_checks++; if (rv !== 2'b00) $display("FAIL read_rvalid_early: got %b want 00", rv); else n_pass++;
        @(negedge clk); #2;
        n_checks++; if (rv !== 2'b10) $display("FAIL read_rvalid: got %b want 10", rv); else n_pass++;
        n_checks++; if (rdata !== 13'h0AAA) $display("FAIL read_rdata: got %h want 0aaa", rdata); else n_pass++;
        @(negedge clk); #2;
        n_checks++; if (rv !== 2'b00) $display("FAIL read_rvalid_late: got %b want 00", rv); else n_pass++;
    endtask

    task automatic test_round_robin();
        int cnt [2];
        logic [1:0] exp_rdy;
        cnt[0] = 0; cnt[1] = 0;
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            if (k != 0) @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                v[n] = (cnt[n] < 4);
                we[n] = 1'b1;
                addr[n] = AW'(k + 16 * n);
                wdata[n] = DW'($urandom);
            end
            #2;
            exp_rdy = (k % 2 == 1) ? 2'b00 : ((((k / 2) % 2) == 0) ? 2'b01 : 2'b10);
            n_checks++;
            if (rdy !== exp_rdy) $display("FAIL rr_grant[%0d]: got %b want %b", k, rdy, exp_rdy);
            else n_pass++;
            for (int n = 0; n < 2; n++) if (rdy[n] && v[n]) cnt[n]++;
        end
        @(negedge clk); v = '0;
        n_checks++;
        if (cnt[0] != 4 || cnt[1] != 4) $display("FAIL rr_count: got %0d %0d want 4 4", cnt[0], cnt[1]);
        else n_pass++;
    endtask

    task automatic test_lock();
        logic [1:0] exp_rdy;
        apply_reset();
        v = 2'b11; we = 2'b11; lock = 2'b01;
        for (int k = 0; k < 18; k++) begin
            if (k != 0) @(negedge clk);
            addr[0] = AW'(k); addr[1] = AW'(k + 12'h100);
            wdata[0] = DW'($urandom); wdata[1] = DW'($urandom);
            #2;
            exp_rdy = (k < MH) ? 2'b01 : ((k == MH) ? 2'b00 : 2'b10);
            n_checks++;
            if (rdy !== exp_rdy) $display("FAIL lock_grant[%0d]: got %b want %b", k, rdy, exp_rdy);
            else n_pass++;
        end
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        v[0] = 1'b1; we[0] = 1'b0; addr[0] = 12'h010; sel[0] = 1'b1;
        #2;
        n_checks++; if (rdy !== 2'b01) $display("FAIL rmid_ready: got %b want 01", rdy); else n_pass++;
        @(negedge clk);
        v = '0;
        reset = 1'b0;
        #2;
        n_checks++;
        if ({rdy, rv, cwr, crd} !== 6'b0) $display("FAIL rmid_ctrl: got %b want 000000", {rdy, rv, cwr, crd});
        else n_pass++;
        n_checks++;
        if ({caddr_wr, caddr_rd, cdata_wr, csel} !== '0)
            $display("FAIL rmid_bus: got %h %h %h %b want zeros", caddr_wr, caddr_rd, cdata_wr, csel);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_checks++; if (rv !== 2'b00) $display("FAIL rmid_rvalid[%0d]: got %b want 00", k, rv); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic          e_cwr, e_crd, e_csel;
        logic [AW-1:0] e_awr, e_ard;
        logic [DW-1:0] e_dwr;
        logic [1:0]    acc, acc_prev, e_rv, exp_rdy;
        int            wait_c [2];
        rd_exp_t       rq [$];
        rd_exp_t       ent;
        logic          due;

        mem_clear = 1'b1;
        @(negedge clk);
        mem_clear = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 4096; a++) ref_mem[s][a] = init_pat(s, a);
        apply_reset();
        e_cwr = 1'b0; e_crd = 1'b0; e_csel = 1'b0; e_awr = '0; e_ard = '0; e_dwr = '0;
        acc_prev = '0; wait_c[0] = 0; wait_c[1] = 0;

        for (int c = 0; c < 2004; c++) begin
            if (c != 0) @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (c >= 2000) begin
                    v[n] = 1'b0;
                end else if (!v[n] || acc_prev[n]) begin
                    v[n]     = ($urandom_range(99) < 60);
                    we[n]    = 1'($urandom_range(1));
                    sel[n]   = 1'($urandom_range(1));
                    addr[n]  = {(($urandom_range(1) == 1) ? 8'hFF : 8'h00), 4'($urandom_range(15))};
                    wdata[n] = DW'($urandom);
                    lock[n]  = ($urandom_range(99) < 40);
                end else if ($urandom_range(99) < 3) begin
                    v[n] = 1'b0;
                end
            end
            #2;

            n_checks++; if (rdy === 2'b11) $display("FAIL rnd_onehot[%0d]: got %b", c, rdy); else n_pass++;
            n_checks++; if ((rdy & ~v) !== 2'b00) $display("FAIL rnd_ready_novalid[%0d]: ready %b valid %b", c, rdy, v); else n_pass++;
            n_checks++; if (cwr === 1'b1 && crd === 1'b1) $display("FAIL rnd_cwr_crd[%0d]: both high", c); else n_pass++;
            n_checks++;
            if ({cwr, crd} !== {e_cwr, e_crd}) $display("FAIL rnd_strobes[%0d]: got %b want %b", c, {cwr, crd}, {e_cwr, e_crd});
            else n_pass++;
            n_checks++;
            if (caddr_wr !== e_awr || cdata_wr !== e_dwr || caddr_rd !== e_ard || csel !== e_csel)
                $display("FAIL rnd_bus[%0d]: got %h %h %h %b want %h %h %h %b",
                         c, caddr_wr, cdata_wr, caddr_rd, csel, e_awr, e_dwr, e_ard, e_csel);
            else n_pass++;

            due  = (rq.size() > 0) && (rq[0].due == c);
            e_rv = due ? (rq[0].id ? 2'b10 : 2'b01) : 2'b00;
            n_checks++; if (rv !== e_rv) $display("FAIL rnd_rvalid[%0d]: got %b want %b", c, rv, e_rv); else n_pass++;
            if (due) begin
                n_checks++;
                if (rdata !== rq[0].data) $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata, rq[0].data);
                else n_pass++;
                void'(rq.pop_front());
            end

            for (int n = 0; n < 2; n++) begin
                if (acc_prev[n]) begin
                    if (v[1-n] && !lock[n]) begin
                        n_checks++;
                        if (rdy !== 2'b00) $display("FAIL rnd_turnaround[%0d]: got %b want 00", c, rdy);
                        else n_pass++;
                    end else if (v[n] && !v[1-n]) begin
                        exp_rdy = (n == 1) ? 2'b10 : 2'b01;
                        n_checks++;
                        if (rdy !== exp_rdy) $display("FAIL rnd_keep[%0d]: got %b want %b", c, rdy, exp_rdy);
                        else n_pass++;
                    end
                end
                if (v[n] && !rdy[n]) begin
                    wait_c[n]++;
                    n_checks++;
                    if (wait_c[n] > MH + 2) $display("FAIL rnd_starve%0d[%0d]: waited %0d want <= %0d", n, c, wait_c[n], MH + 2);
                    else n_pass++;
                end else begin
                    wait_c[n] = 0;
                end
            end

            acc   = v & rdy;
            e_cwr = 1'b0;
            e_crd = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    e_csel = sel[n];
                    if (we[n]) begin
                        e_cwr = 1'b1; e_awr = addr[n]; e_dwr = wdata[n];
                        ref_mem[sel[n]][addr[n]] = wdata[n];
                    end else begin
                        e_crd = 1'b1; e_ard = addr[n];
                        ent.due = c + 2; ent.id = 1'(n); ent.data = ref_mem[sel[n]][addr[n]];
                        rq.push_back(ent);
                    end
                end
            end
            acc_prev = acc;
        end
        n_checks++;
        if (rq.size() != 0) $display("FAIL rnd_drain: %0d reads outstanding want 0", rq.size());
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
